// File: rtl/apu_frame_counter.sv
// APU frame sequencer: emits quarter/half-frame clock enables and the frame IRQ,
// counting CPU cycles in 4-step or 5-step mode, with the delayed $4017 reset.
module apu_frame_counter #(
  parameter int STEP1     = 7457,
  parameter int STEP2     = 14913,
  parameter int STEP3     = 22371,
  parameter int STEP4     = 29829,
  parameter int STEP5     = 37281,
  parameter int CNT_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_clk_en,
  input  logic apu_clk_en,
  input  logic reg_write,
  input  logic reg_mode,
  input  logic reg_irq_inhibit,
  input  logic irq_clear,
  output logic quarter_clk_en,
  output logic half_clk_en,
  output logic frame_irq
);

  localparam logic [CNT_WIDTH-1:0] S1_C   = CNT_WIDTH'(STEP1);
  localparam logic [CNT_WIDTH-1:0] S2_C   = CNT_WIDTH'(STEP2);
  localparam logic [CNT_WIDTH-1:0] S3_C   = CNT_WIDTH'(STEP3);
  localparam logic [CNT_WIDTH-1:0] S4M1_C = CNT_WIDTH'(STEP4 - 1);
  localparam logic [CNT_WIDTH-1:0] S4_C   = CNT_WIDTH'(STEP4);
  localparam logic [CNT_WIDTH-1:0] S5_C   = CNT_WIDTH'(STEP5);
  localparam logic [CNT_WIDTH-1:0] ZERO_C = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] ONE_C  = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           delay_q, delay_d;
  logic mode_q, mode_d, inhibit_q, inhibit_d, irq_q, irq_d;
  logic wrapped_q, wrapped_d, pending_q, pending_d;
  logic ev_quarter_s, ev_half_s, ev_irq_s, ev_wrap_s, expire_s, irq_set_s;

  // A write on the expiry cycle restarts the delay instead of expiring it.
  assign expire_s  = pending_q & (delay_q == 3'd1) & ~reg_write;
  assign irq_set_s = ev_irq_s & ~inhibit_q & ~expire_s;

  always_comb begin
    ev_quarter_s = 1'b0;
    ev_half_s    = 1'b0;
    ev_irq_s     = 1'b0;
    ev_wrap_s    = 1'b0;
    if (!mode_q) begin
      if (cnt_q == S1_C || cnt_q == S3_C) begin
        ev_quarter_s = 1'b1;
      end else if (cnt_q == S2_C) begin
        ev_quarter_s = 1'b1;
        ev_half_s    = 1'b1;
      end else if (cnt_q == S4M1_C) begin
        ev_irq_s = 1'b1;
      end else if (cnt_q == S4_C) begin
        ev_quarter_s = 1'b1;
        ev_half_s    = 1'b1;
        ev_irq_s     = 1'b1;
        ev_wrap_s    = 1'b1;
      end else if (cnt_q == ZERO_C && wrapped_q) begin
        ev_irq_s = 1'b1;
      end else begin
        ev_wrap_s = 1'b0;
      end
    end else begin
      if (cnt_q == S1_C || cnt_q == S3_C) begin
        ev_quarter_s = 1'b1;
      end else if (cnt_q == S2_C) begin
        ev_quarter_s = 1'b1;
        ev_half_s    = 1'b1;
      end else if (cnt_q == S5_C) begin
        ev_quarter_s = 1'b1;
        ev_half_s    = 1'b1;
        ev_wrap_s    = 1'b1;
      end else begin
        ev_wrap_s = 1'b0;
      end
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    delay_d   = delay_q;
    mode_d    = mode_q;
    inhibit_d = inhibit_q;
    irq_d     = irq_q;
    wrapped_d = wrapped_q;
    pending_d = pending_q;
    if (cpu_clk_en) begin
      if (expire_s || ev_wrap_s) begin
        cnt_d = ZERO_C;
      end else begin
        cnt_d = cnt_q + ONE_C;
      end

      if (expire_s) begin
        wrapped_d = 1'b0;
      end else if (ev_wrap_s && !mode_q) begin
        wrapped_d = 1'b1;
      end else if (cnt_q == ZERO_C) begin
        wrapped_d = 1'b0;
      end else begin
        wrapped_d = wrapped_q;
      end

      if (reg_write) begin
        mode_d    = reg_mode;
        inhibit_d = reg_irq_inhibit;
        pending_d = 1'b1;
        delay_d   = apu_clk_en ? 3'd3 : 3'd4;
      end else if (pending_q) begin
        delay_d   = delay_q - 3'd1;
        pending_d = (delay_q != 3'd1);
      end else begin
        delay_d = delay_q;
      end

      // An inhibiting write beats a set event; a set event beats a status read.
      if (reg_write && reg_irq_inhibit) begin
        irq_d = 1'b0;
      end else if (irq_set_s) begin
        irq_d = 1'b1;
      end else if (irq_clear) begin
        irq_d = 1'b0;
      end else begin
        irq_d = irq_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= ZERO_C;
      delay_q   <= 3'd0;
      mode_q    <= 1'b0;
      inhibit_q <= 1'b0;
      irq_q     <= 1'b0;
      wrapped_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      delay_q   <= delay_d;
      mode_q    <= mode_d;
      inhibit_q <= inhibit_d;
      irq_q     <= irq_d;
      wrapped_q <= wrapped_d;
      pending_q <= pending_d;
    end
  end

  // Strobes must coincide with the CPU-cycle enable, so they are decoded from state.
  always_comb begin
    if (cpu_clk_en) begin
      quarter_clk_en = expire_s ? mode_q : ev_quarter_s;
      half_clk_en    = expire_s ? mode_q : ev_half_s;
    end else begin
      quarter_clk_en = 1'b0;
      half_clk_en    = 1'b0;
    end
    frame_irq = irq_q;
  end

endmodule

// File: tb/tb_apu_frame_counter.sv
// Directed bench for apu_frame_counter with shortened step constants; strobe
// positions are logged per segment and compared against hand-computed indices.
module tb_apu_frame_counter;
  localparam int S1 = 7;
  localparam int S2 = 13;
  localparam int S3 = 21;
  localparam int S4 = 29;
  localparam int S5 = 37;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_clk_en = 1'b0;
  logic apu_clk_en = 1'b0;
  logic reg_write = 1'b0;
  logic reg_mode = 1'b0;
  logic reg_irq_inhibit = 1'b0;
  logic irq_clear = 1'b0;
  logic quarter_clk_en, half_clk_en, frame_irq;

  int checks = 0;
  int failures = 0;
  int seg_idx = 0;
  int irq_rise = -1;
  int idle_bad = 0;
  int qlog[$];
  int hlog[$];
  logic apu_ph = 1'b1;

  apu_frame_counter #(
    .STEP1(S1), .STEP2(S2), .STEP3(S3), .STEP4(S4), .STEP5(S5), .CNT_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cpu_clk_en(cpu_clk_en),
    .apu_clk_en(apu_clk_en),
    .reg_write(reg_write),
    .reg_mode(reg_mode),
    .reg_irq_inhibit(reg_irq_inhibit),
    .irq_clear(irq_clear),
    .quarter_clk_en(quarter_clk_en),
    .half_clk_en(half_clk_en),
    .frame_irq(frame_irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // One CPU cycle = one clk with cpu_clk_en high, then one idle clk.
  task automatic cpu_step();
    logic prev_irq;
    @(negedge clk);
    cpu_clk_en = 1'b1;
    apu_clk_en = apu_ph;
    apu_ph = ~apu_ph;
    #1;
    prev_irq = frame_irq;
    if (quarter_clk_en) qlog.push_back(seg_idx);
    if (half_clk_en) hlog.push_back(seg_idx);
    @(negedge clk);
    cpu_clk_en = 1'b0;
    apu_clk_en = 1'b0;
    reg_write = 1'b0;
    irq_clear = 1'b0;
    #1;
    if (quarter_clk_en || half_clk_en) idle_bad++;
    if (frame_irq && !prev_irq && irq_rise < 0) irq_rise = seg_idx;
    seg_idx++;
  endtask

  task automatic run(input int n);
    repeat (n) cpu_step();
  endtask

  task automatic new_seg();
    seg_idx = 0;
    irq_rise = -1;
    qlog.delete();
    hlog.delete();
  endtask

  task automatic write_4017(input bit mode, input bit inh, input bit use_apu, input bit want_apu);
    if (use_apu && apu_ph != want_apu) cpu_step();
    new_seg();
    reg_write = 1'b1;
    reg_mode = mode;
    reg_irq_inhibit = inh;
    cpu_step();
  endtask

  task automatic check_log(input string tag, input bit half, input int n,
                           input int e0, input int e1, input int e2, input int e3, input int e4);
    int exp_v[5];
    int got_n;
    exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3; exp_v[4] = e4;
    got_n = half ? hlog.size() : qlog.size();
    check_eq({tag, "_n"}, got_n, n);
    for (int i = 0; i < n; i++) begin
      int g;
      g = -1;
      if (half) begin
        if (i < hlog.size()) g = hlog[i];
      end else begin
        if (i < qlog.size()) g = qlog[i];
      end
      check_eq($sformatf("%s[%0d]", tag, i), g, exp_v[i]);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_quarter", int'(quarter_clk_en), 0);
    check_eq("rst_half", int'(half_clk_en), 0);
    check_eq("rst_irq", int'(frame_irq), 0);
    @(negedge clk);
    rst = 1'b0;

    // 4-step frame from reset, plus the wrapped cnt=0 step
    new_seg();
    run(31);
    check_log("s1_q", 1'b0, 4, 7, 13, 21, 29, 0);
    check_log("s1_h", 1'b1, 2, 13, 29, 0, 0, 0);
    check_eq("s1_irq_rise", irq_rise, 28);
    check_eq("s1_irq_hold", int'(frame_irq), 1);

    // Status read at cnt=5, then read colliding with the set at cnt=28
    run(4);
    irq_clear = 1'b1;
    cpu_step();
    check_eq("s2_irq_clr", int'(frame_irq), 0);
    new_seg();
    run(22);
    irq_clear = 1'b1;
    cpu_step();
    check_eq("s2_irq_rise", irq_rise, 22);
    check_eq("s2_set_wins", int'(frame_irq), 1);
    check_log("s2_q", 1'b0, 3, 1, 7, 15, 0, 0);

    // Switch to 5-step with apu_clk_en=1: expiry three CPU cycles later
    run(3);
    irq_clear = 1'b1;
    cpu_step();
    check_eq("s3_pre_irq", int'(frame_irq), 0);
    write_4017(1'b1, 1'b0, 1'b1, 1'b1);
    run(45);
    check_log("s3_q", 1'b0, 5, 3, 11, 17, 25, 41);
    check_log("s3_h", 1'b1, 3, 3, 17, 41, 0, 0);
    check_eq("s3_irq_rise", irq_rise, -1);

    // Back to 4-step with apu_clk_en=0: four-cycle delay, silent expiry
    run(4);
    write_4017(1'b0, 1'b0, 1'b1, 1'b0);
    run(35);
    check_log("s4_q", 1'b0, 4, 12, 18, 26, 34, 0);
    check_log("s4_h", 1'b1, 2, 18, 34, 0, 0, 0);
    check_eq("s4_irq_rise", irq_rise, 33);

    // Inhibit write clears the flag and keeps it clear for two frames
    check_eq("s5_pre_irq", int'(frame_irq), 1);
    write_4017(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("s5_inh_clr", int'(frame_irq), 0);
    run(69);
    check_eq("s5_q_count", qlog.size(), 8);
    check_eq("s5_h_count", hlog.size(), 4);
    check_eq("s5_irq_rise", irq_rise, -1);
    check_eq("s5_irq_end", int'(frame_irq), 0);

    // Reset with a 5-step write pending: no stale expiry afterwards
    write_4017(1'b1, 1'b0, 1'b0, 1'b0);
    cpu_step();
    @(negedge clk);
    rst = 1'b1;
    cpu_clk_en = 1'b1;
    #1;
    check_eq("s6_rst_quarter", int'(quarter_clk_en), 0);
    check_eq("s6_rst_half", int'(half_clk_en), 0);
    check_eq("s6_rst_irq", int'(frame_irq), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cpu_clk_en = 1'b0;
    new_seg();
    run(14);
    check_log("s6_q", 1'b0, 2, 7, 13, 0, 0, 0);
    check_log("s6_h", 1'b1, 1, 13, 0, 0, 0, 0);
    check_eq("s6_irq_rise", irq_rise, -1);

    check_eq("idle_strobes", idle_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
